// File: rtl/gray_pkg.sv
// Shared types and helpers for Gray-coded pointer handling.
// The functions work on MAX_WIDTH-bit values; callers zero-extend in and size-cast out.
package gray_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    INIT,
    LOAD,
    TRACK
  } rx_state_e;

  // Zero-extended upper bits decode to zero, so one routine serves every width.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic multi_bit(input logic [MAX_WIDTH-1:0] x);
    return (x & (x - MAX_WIDTH'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_ptr_receiver_if.sv
// Pointer input and decoded-status bundle of the Gray pointer receiver.
interface gray_ptr_receiver_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] gray_in;
  logic             err_clr;
  logic             ready;
  logic [WIDTH-1:0] bin_out;
  logic             changed;
  logic [WIDTH-1:0] delta;
  logic             hop_err;

  modport master (
    output gray_in, err_clr,
    input  ready, bin_out, changed, delta, hop_err
  );

  modport slave (
    input  gray_in, err_clr,
    output ready, bin_out, changed, delta, hop_err
  );

endinterface

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded vector from a foreign clock domain.
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // NOTE: the chain is a flop array, not a memory, so every stage gets the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_ptr_receiver.sv
// Synchronizes a foreign Gray pointer, decodes it, and reports steps, deltas and
// multi-bit hops. WIDTH must not exceed gray_pkg::MAX_WIDTH.
module gray_ptr_receiver
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_ptr_receiver_if.slave  bus
);

  localparam int CNT_W = $clog2(SYNC_STAGES);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             changed_q, changed_d;
  logic             hop_q, hop_d;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] bin_new;

  gray_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.gray_in),
    .q     (gray_s)
  );

  assign diff    = gray_s ^ prev_q;
  assign bin_new = WIDTH'(gray2bin(MAX_WIDTH'(gray_s)));

  // NOTE: every variable gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    bin_d     = bin_q;
    changed_d = 1'b0;
    delta_d   = '0;
    hop_d     = hop_q;
    if (bus.err_clr) hop_d = 1'b0;

    unique case (state_q)
      INIT: begin
        if (cnt_q == CNT_W'(SYNC_STAGES - 1)) state_d = LOAD;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      LOAD: begin
        prev_d  = gray_s;
        bin_d   = bin_new;
        state_d = TRACK;
      end
      TRACK: begin
        if (diff != '0) begin
          changed_d = 1'b1;
          bin_d     = bin_new;
          delta_d   = bin_new - bin_q;
          prev_d    = gray_s;
          // A hop in the same cycle as err_clr must win, hence after the clear.
          if (multi_bit(MAX_WIDTH'(diff))) hop_d = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      cnt_q     <= '0;
      prev_q    <= '0;
      bin_q     <= '0;
      delta_q   <= '0;
      changed_q <= 1'b0;
      hop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      bin_q     <= bin_d;
      delta_q   <= delta_d;
      changed_q <= changed_d;
      hop_q     <= hop_d;
    end
  end

  assign bus.ready   = (state_q == TRACK);
  assign bus.bin_out = bin_q;
  assign bus.changed = changed_q;
  assign bus.delta   = delta_q;
  assign bus.hop_err = hop_q;

endmodule

// File: doc/gray_ptr_receiver.md
# gray_ptr_receiver

Receive-side companion to the binary-to-Gray encoder. It takes a Gray-coded counter or pointer from a foreign clock domain and synchronizes it into `clk` with a multi-flop chain. It then decodes the value to binary and reports each step as a one-cycle `changed` pulse with the modular `delta`, and raises a sticky error if a sample differs from the previous one in more than one bit. It sits at the receiving end of any Gray-coded pointer crossing, such as async FIFO read/write pointer exchange or event counters.

## Interface
Parameters:
- `WIDTH`, 4: pointer width in bits (≥2).
- `SYNC_STAGES`, 2: synchronizer flops (≥2).

Ports:
- `clk`  in  1: sole clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `gray_in`  in  WIDTH: Gray pointer from the foreign domain; asynchronous to `clk`.
- `err_clr`  in  1: synchronous clear of `hop_err`.
- `ready`  out  1: high while in TRACK; `bin_out` is meaningful only when high.
- `bin_out`  out  WIDTH: registered binary value of the synchronized pointer.
- `changed`  out  1: one-cycle pulse when the synchronized pointer changed.
- `delta`  out  WIDTH: (new − old) mod 2^WIDTH, valid while `changed`=1, else 0.
- `hop_err`  out  1: sticky; set on any multi-bit Gray change.

## Operation
- Decode rule: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] for i descending.
- Synchronizer: `SYNC_STAGES` flops on `gray_in`, all reset to 0. `gray_s` is the last stage.
- FSM states:
  - **INIT** (reset state): a counter counts `SYNC_STAGES` cycles so the chain is flushed with real input, then the FSM moves to LOAD.
  - **LOAD** (one cycle): captures `gray_prev`←`gray_s` and `bin_out`←decode(`gray_s`). No `changed`, no `hop_err`. Next state is TRACK.
  - **TRACK**: each cycle computes `diff = gray_s ^ gray_prev`.
    - diff==0: `changed`=0, `delta`=0.
    - popcount(diff)==1: `changed`=1, `bin_out`←new, `delta`←new−old (modulo), `gray_prev`←`gray_s`.
    - popcount(diff)>1: same updates as the single-bit case, and additionally `hop_err`←1.
- `err_clr` clears `hop_err` the following cycle. If a new hop occurs in the same cycle as `err_clr`, the set wins.
- Wrap-around is legal: binary 2^WIDTH−1 → 0 gives `delta`=1. A single-step decrement gives `delta`=2^WIDTH−1.
- `err_clr` in INIT or LOAD clears `hop_err` normally.

## Timing
- Reset values: `ready`=0, `bin_out`=0, `changed`=0, `delta`=0, `hop_err`=0, FSM=INIT, sync chain=0, `gray_prev`=0.
- Reset asserts asynchronously and outputs go to reset values immediately. Reset release is sampled on `clk`.
- After release: INIT lasts `SYNC_STAGES` cycles, then LOAD for 1 cycle. `ready`=1 from cycle `SYNC_STAGES`+1 onward.
- Latency in TRACK: a `gray_in` change stable before edge N produces `changed`/`bin_out`/`delta` visible after edge N+`SYNC_STAGES`. That is `SYNC_STAGES`+1 edges counting the output register.
- Input changes spaced ≥1 cycle apart each produce their own `changed` pulse. Back-to-back changes produce back-to-back pulses with no gap.
- Reset mid-TRACK: all state is discarded, and the full INIT→LOAD sequence repeats after release.

## Structure
- Shared package `gray_pkg`:
  - state typedef (`INIT`, `LOAD`, `TRACK`);
  - functions `gray2bin` and `bin2gray`, parameterized by width via the call site;
  - a popcount-greater-than-one helper.
- One natural sub-module: `gray_sync`, the `SYNC_STAGES`-deep reset-to-0 synchronizer vector. The FSM, decode and compare stay in the top level.

## Test plan
Parameters: WIDTH=4, SYNC_STAGES=2; clk 10 ns.
1. Bring-up: reset with `gray_in`=0000, release → `ready` rises 3 cycles later, `bin_out`=0000, no `changed` pulse.
2. Count-up: `gray_in` 0000→0001→0011→0010, 5 cycles apart → `bin_out` 1, 2, 3. Each step gives a `changed` pulse 3 edges after the input change, `delta`=0001, `hop_err`=0.
3. Wrap and decrement:
   - 1000 (bin 15) → 0000 gives `bin_out`=0, `delta`=0001.
   - 0011 → 0001 gives `bin_out`=1, `delta`=1111.
   - `hop_err` stays 0 throughout.
4. Hop error: 0000→0011 → `changed` pulses, `bin_out`=0010, `delta`=0010, `hop_err`=1 and held. Then:
   - `err_clr` alone → `hop_err`=0 next cycle.
   - `err_clr` coincident with hop 0011→0110 → `hop_err` stays 1.
5. Reset mid-operation: in TRACK with `bin_out`=0101, assert `rst_n`=0 → outputs 0 without a clock edge. Release with `gray_in`=0101 (bin 6) → after INIT/LOAD `bin_out`=0110, no `changed` pulse, `hop_err`=0.
6. Back-to-back: `gray_in` steps 0000→0001→0011 on consecutive cycles → two consecutive `changed` pulses, each with `delta`=0001.
